// File: rtl/fpga_config_loader.sv
// rtl/fpga_config_loader.sv - byte-stream loader for the LUT fabric config registers
// Frame: HEADER, then {truth[7:0], truth[15:8], sel} per LUT, then XOR checksum of the payload.
module fpga_config_loader #(
  parameter int unsigned NUM_LUTS = 15,
  parameter logic [7:0]  HEADER   = 8'hA5,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        cfg_we,
  output logic [3:0]  cfg_addr,
  output logic [15:0] cfg_truth,
  output logic [7:0]  cfg_sel,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        fabric_en
);
  localparam int unsigned TW       = $clog2(TIMEOUT + 1);
  localparam logic [3:0]  LAST_LUT = 4'(NUM_LUTS - 1);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_LOAD, S_CHK, S_DONE, S_ERR} state_t;

  state_t        state_q, state_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [3:0]    lut_idx_q, lut_idx_d;
  logic [7:0]    csum_q, csum_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [TW-1:0] tmo_inc;
  logic [15:0]   truth_q, truth_d;
  logic          cfg_we_q, cfg_we_d;
  logic [3:0]    cfg_addr_q, cfg_addr_d;
  logic [15:0]   cfg_truth_q, cfg_truth_d;
  logic [7:0]    cfg_sel_q, cfg_sel_d;
  logic          accept;

  assign busy      = (state_q == S_HDR) || (state_q == S_LOAD) || (state_q == S_CHK);
  assign in_ready  = busy;
  assign accept    = in_valid && busy;
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_ERR);
  assign fabric_en = done;
  assign cfg_we    = cfg_we_q;
  assign cfg_addr  = cfg_addr_q;
  assign cfg_truth = cfg_truth_q;
  assign cfg_sel   = cfg_sel_q;

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    lut_idx_d   = lut_idx_q;
    csum_d      = csum_q;
    tmo_d       = tmo_q;
    truth_d     = truth_q;
    cfg_we_d    = 1'b0;
    cfg_addr_d  = cfg_addr_q;
    cfg_truth_d = cfg_truth_q;
    cfg_sel_d   = cfg_sel_q;
    tmo_inc     = tmo_q + TW'(1);
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_HDR;
          byte_cnt_d = '0;
          lut_idx_d  = '0;
          csum_d     = '0;
          tmo_d      = '0;
        end
      end
      S_HDR, S_LOAD, S_CHK: begin
        if (!accept) begin
          tmo_d = tmo_inc;
          if (tmo_inc == TW'(TIMEOUT)) state_d = S_ERR;
        end else begin
          tmo_d = '0;
          if (state_q == S_HDR) begin
            state_d = (in_data == HEADER) ? S_LOAD : S_ERR;
          end else if (state_q == S_CHK) begin
            state_d = (in_data == csum_q) ? S_DONE : S_ERR;
          end else begin
            csum_d = csum_q ^ in_data;
            if (byte_cnt_q == 2'd0) begin
              truth_d[7:0] = in_data;
              byte_cnt_d   = 2'd1;
            end else if (byte_cnt_q == 2'd1) begin
              truth_d[15:8] = in_data;
              byte_cnt_d    = 2'd2;
            end else begin
              // Third byte completes the LUT: the write strobe lands on the next cycle.
              byte_cnt_d  = 2'd0;
              cfg_we_d    = 1'b1;
              cfg_addr_d  = lut_idx_q;
              cfg_truth_d = truth_q;
              cfg_sel_d   = in_data;
              lut_idx_d   = lut_idx_q + 4'd1;
              if (lut_idx_q == LAST_LUT) state_d = S_CHK;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      byte_cnt_q  <= '0;
      lut_idx_q   <= '0;
      csum_q      <= '0;
      tmo_q       <= '0;
      truth_q     <= '0;
      cfg_we_q    <= 1'b0;
      cfg_addr_q  <= '0;
      cfg_truth_q <= '0;
      cfg_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      lut_idx_q   <= lut_idx_d;
      csum_q      <= csum_d;
      tmo_q       <= tmo_d;
      truth_q     <= truth_d;
      cfg_we_q    <= cfg_we_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_truth_q <= cfg_truth_d;
      cfg_sel_q   <= cfg_sel_d;
    end
  end

endmodule

// File: tb/tb_fpga_config_loader.sv
// tb/tb_fpga_config_loader.sv - self-checking bench for fpga_config_loader
`timescale 1ns/1ps
module tb_fpga_config_loader;
  localparam int NL  = 15;
  localparam int TMO = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, cfg_we, busy, done, err, fabric_en;
  logic [3:0]  cfg_addr;
  logic [15:0] cfg_truth;
  logic [7:0]  cfg_sel;

  fpga_config_loader #(.NUM_LUTS(NL), .HEADER(8'hA5), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_truth(cfg_truth),
    .cfg_sel(cfg_sel), .busy(busy), .done(done), .err(err), .fabric_en(fabric_en)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Observed config writes, captured away from the active edge
  logic [27:0] wr_q[$];
  int          wr_cyc[$];
  always @(negedge clk) begin
    if (cfg_we) begin
      wr_q.push_back({cfg_addr, cfg_truth, cfg_sel});
      wr_cyc.push_back(cyc);
    end
  end

  // Reference model: the intended LUT contents and the frame that carries them
  logic [15:0] m_truth [NL];
  logic [7:0]  m_sel   [NL];
  logic [7:0]  frame[$];
  int          hdr_cyc;

  task automatic make_frame(input logic [7:0] hdr, input logic [7:0] flip);
    logic [7:0] x;
    x = 8'h00;
    frame.delete();
    frame.push_back(hdr);
    for (int k = 0; k < NL; k++) begin
      frame.push_back(m_truth[k][7:0]);
      frame.push_back(m_truth[k][15:8]);
      frame.push_back(m_sel[k]);
      x = x ^ m_truth[k][7:0] ^ m_truth[k][15:8] ^ m_sel[k];
    end
    frame.push_back(x ^ flip);
  endtask

  task automatic randomize_model();
    for (int k = 0; k < NL; k++) begin
      m_truth[k] = 16'($urandom);
      m_sel[k]   = 8'($urandom);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_bytes(input int lo, input int hi, input int gap_max, input int start_at);
    int g;
    for (int i = lo; i < hi; i++) begin
      g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      for (int j = 0; j < g; j++) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = frame[i];
      start    = (i == start_at);
      if (i == 0) hdr_cyc = cyc;
      @(negedge clk);
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic check_writes(input string tag, input int n);
    check($sformatf("%s_wr_count", tag), wr_q.size(), n);
    for (int k = 0; k < n && k < wr_q.size(); k++)
      check($sformatf("%s_wr%0d", tag, k), wr_q[k], {4'(k), m_truth[k], m_sel[k]});
  endtask

  initial begin
    logic [7:0] flip;
    logic       saw_ready;
    int         n;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_cfg_we", cfg_we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_fabric_en", fabric_en, 0);
    check("rst_cfg_addr", cfg_addr, 0);
    check("rst_cfg_truth", cfg_truth, 0);
    check("rst_cfg_sel", cfg_sel, 0);

    // Nominal frame, back-to-back
    for (int k = 0; k < NL; k++) begin
      m_truth[k] = 16'(k);
      m_sel[k]   = 8'hE4;
    end
    make_frame(8'hA5, 8'h00);
    wr_q.delete(); wr_cyc.delete();
    pulse_start();
    check("hdr_busy", busy, 1);
    check("hdr_in_ready", in_ready, 1);
    n = frame.size();
    send_bytes(0, n - 1, 0, -1);
    check("nom_done_before_chk", done, 0);
    send_bytes(n - 1, n, 0, -1);
    check("nom_done", done, 1);
    check("nom_fabric_en", fabric_en, 1);
    check("nom_err", err, 0);
    check("nom_busy", busy, 0);
    check("nom_in_ready", in_ready, 0);
    check_writes("nom", NL);
    if (wr_cyc.size() > 0) check("nom_first_we_latency", wr_cyc[0] - hdr_cyc, 4);

    // Bad checksum
    make_frame(8'hA5, 8'h01);
    wr_q.delete(); wr_cyc.delete();
    pulse_start();
    send_bytes(0, frame.size(), 0, -1);
    check("badck_err", err, 1);
    check("badck_done", done, 0);
    check("badck_fabric_en", fabric_en, 0);
    check_writes("badck", NL);

    // Start from ERR, random frame with gaps and a stray start mid-LOAD
    randomize_model();
    make_frame(8'hA5, 8'h00);
    wr_q.delete(); wr_cyc.delete();
    pulse_start();
    check("restart_err_clr", err, 0);
    check("restart_done_clr", done, 0);
    check("restart_busy", busy, 1);
    send_bytes(0, frame.size(), 3, int'($urandom_range(3 * NL, 5)));
    check("restart_done", done, 1);
    check("restart_err", err, 0);
    check_writes("restart", NL);

    // Bad header
    wr_q.delete(); wr_cyc.delete();
    pulse_start();
    in_valid = 1'b1;
    in_data  = 8'h5A;
    @(negedge clk);
    in_valid = 1'b0;
    check("badhdr_err", err, 1);
    check("badhdr_in_ready", in_ready, 0);
    check("badhdr_done", done, 0);
    repeat (4) @(negedge clk);
    check("badhdr_wr_count", wr_q.size(), 0);

    // Timeout after two payload bytes
    make_frame(8'hA5, 8'h00);
    wr_q.delete(); wr_cyc.delete();
    pulse_start();
    send_bytes(0, 3, 0, -1);
    repeat (TMO - 1) @(negedge clk);
    check("tmo_err_early", err, 0);
    check("tmo_busy_early", busy, 1);
    @(negedge clk);
    check("tmo_err", err, 1);
    check("tmo_busy", busy, 0);
    check("tmo_wr_count", wr_q.size(), 0);

    // Randomized frames, sometimes with a corrupted checksum
    for (int it = 0; it < 4; it++) begin
      randomize_model();
      flip = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
      make_frame(8'hA5, flip);
      wr_q.delete(); wr_cyc.delete();
      pulse_start();
      send_bytes(0, frame.size(), 3, int'($urandom_range(3 * NL, 2)));
      check($sformatf("rnd%0d_done", it), done, (flip == 8'h00) ? 1 : 0);
      check($sformatf("rnd%0d_err", it), err, (flip != 8'h00) ? 1 : 0);
      check($sformatf("rnd%0d_fabric_en", it), fabric_en, (flip == 8'h00) ? 1 : 0);
      check_writes($sformatf("rnd%0d", it), NL);
    end

    // Reset asserted right after LUT 5 is written
    randomize_model();
    make_frame(8'hA5, 8'h00);
    wr_q.delete(); wr_cyc.delete();
    pulse_start();
    send_bytes(0, 1 + 3 * 6, 0, -1);
    in_valid = 1'b1;
    in_data  = frame[19];
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_cfg_we", cfg_we, 0);
    check("rstmid_cfg_addr", cfg_addr, 0);
    check("rstmid_cfg_truth", cfg_truth, 0);
    check("rstmid_cfg_sel", cfg_sel, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_in_ready", in_ready, 0);
    check("rstmid_done", done, 0);
    check("rstmid_err", err, 0);
    check("rstmid_fabric_en", fabric_en, 0);
    check_writes("rstmid", 6);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw_ready = 1'b0;
    for (int i = 20; i < 30; i++) begin
      in_valid = 1'b1;
      in_data  = frame[i];
      @(negedge clk);
      saw_ready = saw_ready | in_ready;
    end
    in_valid = 1'b0;
    check("rstmid_post_in_ready", saw_ready, 0);
    check("rstmid_post_busy", busy, 0);
    check("rstmid_post_wr_count", wr_q.size(), 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fpga_config_loader.md
Name: fpga_config_loader

Overview:
- Loads configuration into the LUT fabric of the generated fpga_design array, one LUT at a time, from a byte-wide bitstream stream.
- Per LUT it writes a 16-bit truth table plus four 2-bit input selects, where input select k picks fpga_in_0..3 for lut_in_k.
- Validates a header byte and a trailing XOR checksum, and enables the fabric outputs only after a good load.
- Sits between the bitstream source (host or bitstream validator) and the fabric config registers.

Parameters:
- NUM_LUTS, 15, number of LUTs configured per frame.
- HEADER, 8'hA5, required first byte of a frame.
- TIMEOUT, 1024, maximum idle cycles between accepted bytes while loading.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins a frame load.
- in_valid  in  1  byte valid.
- in_data  in  8  bitstream byte.
- in_ready  out  1  loader accepts a byte when in_valid && in_ready.
- cfg_we  out  1  one-cycle write strobe to the fabric config registers.
- cfg_addr  out  4  LUT index being written, 0..NUM_LUTS-1.
- cfg_truth  out  16  truth table; bit i is the output for {in3,in2,in1,in0}==i.
- cfg_sel  out  8  input selects: [1:0]=in0, [3:2]=in1, [5:4]=in2, [7:6]=in3.
- busy  out  1  high in HDR, LOAD or CHK.
- done  out  1  frame loaded and checksum matched.
- err  out  1  header, checksum or timeout failure.
- fabric_en  out  1  gates the fabric outputs; equals done.

Behaviour:
- Reset: the block is in IDLE. in_ready, cfg_we, busy, done, err and fabric_en are 0. cfg_addr, cfg_truth and cfg_sel are 0. The byte counter, LUT index, checksum accumulator and timeout counter are 0.
- Reset asserted mid-load aborts immediately to the reset state. No further cfg_we is issued.
- States: IDLE, HDR, LOAD, CHK, DONE, ERR.
- IDLE, DONE, ERR: start moves the block to HDR next cycle. On entry to HDR, done, err, fabric_en, LUT index, byte counter, checksum and timeout counter are all cleared. in_ready=0 in these three states. Bytes presented here are ignored.
- HDR, LOAD, CHK: in_ready=1, busy=1. start is ignored.
- HDR: the accepted byte is compared with HEADER. Equal goes to LOAD; unequal goes to ERR. The header byte is not included in the checksum.
- LOAD: three bytes are accepted per LUT, in this order: truth[7:0], truth[15:8], sel[7:0].
  - Each accepted payload byte is XORed into the checksum accumulator.
  - On the cycle after the third byte is accepted, cfg_we=1 for exactly one cycle, with cfg_addr equal to the current LUT index and cfg_truth/cfg_sel holding the assembled values.
  - The LUT index then increments.
  - When the write for index NUM_LUTS-1 issues, the next state is CHK.
  - A byte may be accepted in the same cycle cfg_we is high. There is no back-pressure.
- CHK: the accepted byte is compared with the accumulator. Equal goes to DONE (done=1, fabric_en=1). Unequal goes to ERR (err=1, fabric_en=0).
- Previously written LUT configs are not rolled back on error. fabric_en=0 keeps the outputs gated.
- Timeout: in HDR, LOAD or CHK the counter increments on every cycle with no accepted byte and clears on every accepted byte. Reaching TIMEOUT goes to ERR (err=1).
- cfg_addr, cfg_truth and cfg_sel hold their last values between writes.
- Latency, with no stalls: the first cfg_we comes 4 cycles after the HDR byte is accepted. done rises 1 cycle after the checksum byte is accepted. A full frame is 2 + 3*NUM_LUTS bytes.

Test Plan:
- Nominal load:
  - Stimulus: start, then 0xA5, then for k=0..14 the bytes {k, 0x00, 0xE4}, then checksum 0xEB, all back-to-back.
  - Required: 15 cfg_we pulses with cfg_addr=k, cfg_truth=16'h00kk and cfg_sel=8'hE4; done=fabric_en=1; err=0; busy=0 after done.
- Bad checksum: same frame with checksum 0xEA -> 15 writes occur, then err=1, done=0, fabric_en=0.
- Bad header: start, then 0x5A -> ERR the next cycle, no cfg_we, in_ready=0.
- Timeout: start, 0xA5, two payload bytes, then in_valid=0 for 1024 cycles -> err=1 at exactly cycle 1024 of idleness, no cfg_we issued.
- Restart and ignore:
  - start pulsed mid-LOAD -> no effect, and the frame completes normally.
  - start pulsed in ERR -> done/err clear and a new frame loads correctly.
- Reset mid-load: rst_n low after LUT 5 is written -> all outputs 0 asynchronously; after release, IDLE with in_ready=0 and no further cfg_we.
